// File: rtl/lea_byte_loader.sv
// Byte-serial loader for the LEA register bank: steers each accepted byte into one
// 8-bit register via a one-hot enable, then holds the full bank until the core acks.
module lea_byte_loader #(
  parameter int NBYTES = 16,
  parameter int CW     = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              clear,
  output logic [NBYTES-1:0] reg_ce,
  output logic [7:0]        reg_din,
  output logic              blk_valid,
  input  logic              blk_ack,
  output logic [CW-1:0]     byte_cnt
);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          accept;
  logic          last;

  assign last = (cnt_reg == CW'(NBYTES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= LOAD;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Reset and clear both gate in_ready, so upstream never loses a byte to them.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    if (clear) begin
      state_next = LOAD;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        LOAD: begin
          in_ready = ~Reset;
          accept   = in_valid & ~Reset;
          if (accept) begin
            if (last) begin
              cnt_next   = '0;
              state_next = FULL;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
        end
        FULL: begin
          if (blk_ack) state_next = LOAD;
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // Bit k fires only when the accepted byte belongs to register k.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_ce
    assign reg_ce[gi] = accept && (cnt_reg == CW'(gi));
  end

  assign reg_din   = in_data;
  assign blk_valid = (state_reg == FULL);
  assign byte_cnt  = cnt_reg;

endmodule

// File: tb/tb_lea_byte_loader.sv
// Bench for lea_byte_loader: 16- and 32-byte instances share stimulus and are each
// checked against a counter/array reference model plus an external register bank.
module tb_lea_byte_loader;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, in_valid, clear, blk_ack;
  logic [7:0] in_data;

  logic        rdy16, bv16, rdy32, bv32;
  logic [15:0] ce16;
  logic [31:0] ce32;
  logic [7:0]  din16, din32;
  logic [4:0]  cnt16, cnt32;

  lea_byte_loader #(.NBYTES(16), .CW(5)) dut16 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy16), .clear(clear), .reg_ce(ce16), .reg_din(din16),
    .blk_valid(bv16), .blk_ack(blk_ack), .byte_cnt(cnt16));

  lea_byte_loader #(.NBYTES(32), .CW(5)) dut32 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy32), .clear(clear), .reg_ce(ce32), .reg_din(din32),
    .blk_valid(bv32), .blk_ack(blk_ack), .byte_cnt(cnt32));

  // Downstream Ce-enabled register banks
  logic [7:0] bank16 [16];
  logic [7:0] bank32 [32];
  always @(posedge Clk) begin
    for (int k = 0; k < 16; k++) if (ce16[k]) bank16[k] <= din16;
    for (int k = 0; k < 32; k++) if (ce32[k]) bank32[k] <= din32;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: block fill level, full flag and expected bank contents
  int         nb [2] = '{16, 32};
  int         m_cnt [2];
  bit         m_full [2];
  logic [7:0] m_bank [2][32];
  bit         model_on = 1'b0;
  bit         cur_r, cur_v, cur_c, cur_a;
  logic [7:0] cur_d;

  task automatic drive_check(input bit r, input bit v, input logic [7:0] d, input bit c, input bit a);
    bit          exp_rdy, acc;
    logic [31:0] exp_ce, act_ce;
    logic [255:0] act_b, exp_b;
    cur_r = r; cur_v = v; cur_d = d; cur_c = c; cur_a = a;
    Reset = r; in_valid = v; in_data = d; clear = c; blk_ack = a;
    #1;
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        exp_rdy = !r && !c && !m_full[i];
        acc     = exp_rdy && v;
        exp_ce  = acc ? (32'd1 << m_cnt[i]) : 32'd0;
        act_ce  = (i == 0) ? {16'd0, ce16} : ce32;
        chk($sformatf("ready%0d", nb[i]), (i == 0) ? rdy16 : rdy32, exp_rdy);
        chk($sformatf("reg_ce%0d", nb[i]), act_ce, exp_ce);
        chk($sformatf("byte_cnt%0d", nb[i]), (i == 0) ? cnt16 : cnt32, m_cnt[i]);
        chk($sformatf("blk_valid%0d", nb[i]), (i == 0) ? bv16 : bv32, m_full[i]);
        if (acc) chk($sformatf("reg_din%0d", nb[i]), (i == 0) ? din16 : din32, d);
        if (m_full[i]) begin
          act_b = '0; exp_b = '0;
          for (int k = 0; k < nb[i]; k++) begin
            act_b[k*8 +: 8] = (i == 0) ? bank16[k] : bank32[k];
            exp_b[k*8 +: 8] = m_bank[i][k];
          end
          chk_wide($sformatf("bank%0d", nb[i]), act_b, exp_b);
        end
      end
    end
  endtask

  task automatic advance();
    bit acc;
    for (int i = 0; i < 2; i++) begin
      acc = !cur_r && !cur_c && !m_full[i] && cur_v;
      if (cur_r || cur_c) begin
        m_cnt[i] = 0; m_full[i] = 1'b0;
      end else if (m_full[i]) begin
        if (cur_a) m_full[i] = 1'b0;
      end else if (acc) begin
        m_bank[i][m_cnt[i]] = cur_d;
        if (m_cnt[i] == nb[i] - 1) begin
          m_cnt[i] = 0; m_full[i] = 1'b1;
        end else begin
          m_cnt[i]++;
        end
      end
    end
    if (cur_r) model_on = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  typedef struct {
    bit r, v, c, a;
    logic [7:0] d;
    bit e_ready;
    logic [15:0] e_ce;
    int e_cnt;   // -1: don't care
  } vec_t;

  initial begin
    vec_t tbl [13];
    logic [127:0] blk;
    tbl[0]  = '{1, 1, 0, 0, 8'h55, 0, 16'h0000, -1};
    tbl[1]  = '{1, 1, 0, 0, 8'h55, 0, 16'h0000,  0};
    tbl[2]  = '{0, 1, 0, 0, 8'hA0, 1, 16'h0001,  0};
    tbl[3]  = '{0, 0, 0, 0, 8'h11, 1, 16'h0000,  1};
    tbl[4]  = '{0, 1, 0, 0, 8'hA1, 1, 16'h0002,  1};
    tbl[5]  = '{0, 0, 0, 0, 8'h22, 1, 16'h0000,  2};
    tbl[6]  = '{0, 1, 0, 0, 8'hA2, 1, 16'h0004,  2};
    tbl[7]  = '{0, 1, 0, 0, 8'hA3, 1, 16'h0008,  3};
    tbl[8]  = '{0, 1, 0, 0, 8'hA4, 1, 16'h0010,  4};
    tbl[9]  = '{0, 1, 0, 0, 8'hA5, 1, 16'h0020,  5};
    tbl[10] = '{0, 1, 0, 0, 8'hA6, 1, 16'h0040,  6};
    tbl[11] = '{0, 1, 1, 0, 8'hEE, 0, 16'h0000,  7};
    tbl[12] = '{0, 0, 0, 0, 8'h00, 1, 16'h0000,  0};

    Reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; blk_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_full[i] = 1'b0;
    end
    @(negedge Clk);

    // Reset, bubbles and mid-block clear
    for (int t = 0; t < 13; t++) begin
      drive_check(tbl[t].r, tbl[t].v, tbl[t].d, tbl[t].c, tbl[t].a);
      chk($sformatf("tbl%0d_ready", t), rdy16, tbl[t].e_ready);
      chk($sformatf("tbl%0d_ce", t), ce16, tbl[t].e_ce);
      if (tbl[t].e_cnt >= 0) begin
        chk($sformatf("tbl%0d_cnt", t), cnt16, tbl[t].e_cnt);
        chk($sformatf("tbl%0d_blk_valid", t), bv16, 1'b0);
      end
      advance();
    end

    // Full 16-byte block, back-to-back
    for (int k = 0; k < 16; k++) begin
      drive_check(0, 1, k[7:0], 0, 0);
      chk($sformatf("walk_ce%0d", k), ce16, 16'd1 << k);
      advance();
    end
    drive_check(0, 0, 8'h00, 0, 0);
    chk("blk_valid_at_17", bv16, 1'b1);
    for (int k = 0; k < 16; k++) blk[k*8 +: 8] = bank16[k];
    chk_wide("bank16_block", {128'd0, blk}, {128'd0, 128'h0F0E0D0C_0B0A0908_07060504_03020100});
    advance();

    // Backpressure while FULL, then ack
    for (int k = 0; k < 5; k++) begin
      drive_check(0, 1, 8'hAA, 0, 0);
      chk("hold_ce16", ce16, 16'h0000);
      advance();
    end
    for (int k = 0; k < 16; k++) blk[k*8 +: 8] = bank16[k];
    chk_wide("bank16_held", {128'd0, blk}, {128'd0, 128'h0F0E0D0C_0B0A0908_07060504_03020100});
    drive_check(0, 1, 8'hAA, 0, 1);
    chk("ack_cycle_ce16", ce16, 16'h0000);
    advance();
    drive_check(0, 1, 8'hAA, 0, 0);
    chk("post_ack_ce16", ce16, 16'h0001);
    advance();
    chk("bank16_reg0", bank16[0], 8'hAA);

    // Finish the 32-byte block (dut32 is at byte 23 here)
    chk("cnt32_before_tail", cnt32, 5'd23);
    for (int k = 23; k < 32; k++) begin
      drive_check(0, 1, 8'(k * 7), 0, 0);
      if (k == 31) chk("last_ce32", ce32, 32'h8000_0000);
      advance();
    end
    drive_check(0, 0, 8'h00, 0, 0);
    chk("blk_valid32", bv32, 1'b1);
    advance();
    drive_check(0, 1, 8'h33, 1, 1);
    chk("clr_ack_ce32", ce32, 32'd0);
    advance();
    drive_check(0, 0, 8'h00, 0, 0);
    chk("clr_ack_cnt32", cnt32, 5'd0);
    chk("clr_ack_bv32", bv32, 1'b0);
    chk("clr_ack_ready32", rdy32, 1'b1);
    advance();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      drive_check($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, 8'($urandom),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
